disp_mux_pwm: RTL and testbench
===============================

// Module: disp_mux_pwm
// PURPOSE
//  Time-multiplexed seven-segment display driver for NUM_DIGITS common-anode/cathode digits.
//  Successor to the fixed 4-digit scanner, adding:
//   - configurable digit count and per-digit slot time
//   - per-digit blanking and global brightness PWM
//   - tear-free double-buffered data update
//  Sits between display-formatting logic (hex/BCD encoders) and the board pins.
// PARAMETERS
//  NUM_DIGITS      8     number of digits scanned, >=2
//  PRESCALE        1024  clk cycles per digit slot; multiple of 2**BRIGHT_W, >=2**BRIGHT_W
//  BRIGHT_W        4     brightness control width
//  AN_ACTIVE_LOW   1     1: anode select driven low to enable a digit
//  SEG_ACTIVE_LOW  1     1: segment lit when bit=0; blank pattern = all ones
// PORTS
//  clk         in   1              clock
//  reset       in   1              asynchronous, active-high
//  seg_data    in   8*NUM_DIGITS   digit i pattern at [8*i+7:8*i]; bit7=dp, bits6:0=g..a
//  digit_en    in   NUM_DIGITS     1=digit shown, 0=digit blanked
//  load        in   1              capture seg_data/digit_en into pending buffer
//  brightness  in   BRIGHT_W       duty level, 0=dimmest (1/2**BRIGHT_W), max=100%
//  an          out  NUM_DIGITS     digit select, one-hot in active polarity
//  sseg        out  8              segment pattern of selected digit
//  frame_tick  out  1              1-cycle pulse when scan wraps to digit 0
// BEHAVIOUR
//  Reset (async, active-high) values:
//   - pre_cnt=0, dig_idx=0
//   - pending and active data = blank pattern; pending and active enables = 0
//   - an = all inactive; sseg = blank pattern; frame_tick=0
//  Prescaler:
//   - pre_cnt counts 0..PRESCALE-1, then wraps to 0.
//   - On the wrap cycle dig_idx increments; NUM_DIGITS-1 -> 0.
//  frame_tick:
//   - Registered; asserted for exactly the one cycle in which dig_idx goes 0 -> ... i.e. registers the NUM_DIGITS-1 -> 0 step.
//   - Period = NUM_DIGITS*PRESCALE cycles.
//  Buffering:
//   - load=1: pending <= {seg_data,digit_en}.
//   - At the frame boundary (the cycle dig_idx wraps to 0): active <= pending.
//   - load coincident with the boundary: active <= seg_data/digit_en directly, and pending is updated too.
//   - active never changes mid-frame; no partial-frame tearing.
//  Lit condition:
//   - lit = active_en[dig_idx] && (pre_cnt < (brightness+1)*(PRESCALE>>BRIGHT_W)).
//   - Computed at full width; no overflow at max brightness.
//  Outputs:
//   - Registered, 1-cycle latency after pre_cnt/dig_idx.
//   - lit=1: an = one-hot(dig_idx) in AN polarity; sseg = active_data[dig_idx] (passed through unmodified).
//   - lit=0: an = all inactive; sseg = blank pattern.
//   - Exactly one or zero an bits active at any cycle.
//  brightness is sampled live each cycle; a change takes effect within the current slot.
//  Reset asserted mid-frame: immediate return to reset values; scan restarts at digit 0 after release.
// TESTING
//  1. Reset, NUM_DIGITS=4, PRESCALE=16, BRIGHT_W=2; no load.
//     -> an=4'b1111, sseg=8'hFF for 200 cycles; frame_tick every 64 cycles.
//  2. load with seg_data={8'hC0,8'hF9,8'hA4,8'hB0}, digit_en=4'hF, brightness=3, then wait for the boundary.
//     -> slot 0: an=1110, sseg=8'hB0; slot 1: an=1101, sseg=8'hA4; ... 16 cycles per slot; an never changes mid-frame.
//  3. brightness=0.
//     -> an active 4 of 16 cycles per slot, blank for the other 12.
//     brightness=2 -> active 12 of 16 cycles.
//  4. digit_en=4'b0101.
//     -> digits 1 and 3 never selected; their slots show an=1111, sseg=FF.
//  5. load in mid-frame with new data.
//     -> old data is shown until frame_tick; new data appears from digit 0 of the next frame.
//     load on the exact boundary cycle -> new data shown in that frame.
//  6. Assert reset during slot 2.
//     -> an=1111, sseg=FF immediately; after release the first lit digit is 0; enables stay cleared until the next load.

Source files
------------

// File: rtl/disp_mux_pwm_if.sv
// Bus between the display-formatting logic (master) and the seven-segment
// scan driver (slave). Board-pin outputs travel back on the same bundle.
//
// load is a single-cycle capture strobe with no ready: the driver always
// accepts it, so every cycle with load=1 is one capture of seg_data/digit_en.
interface disp_mux_pwm_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BRIGHT_W   = 4
);
    logic [8*NUM_DIGITS-1:0] seg_data;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [BRIGHT_W-1:0]     brightness;
    logic [NUM_DIGITS-1:0]   an;
    logic [7:0]              sseg;
    logic                    frame_tick;

    modport master (
        output seg_data, digit_en, load, brightness,
        input  an, sseg, frame_tick
    );

    modport slave (
        input  seg_data, digit_en, load, brightness,
        output an, sseg, frame_tick
    );
endinterface

// File: rtl/disp_mux_pwm.sv
// Time-multiplexed seven-segment driver with per-digit blanking, brightness
// PWM inside each digit slot, and a double-buffered pattern store that only
// swaps at the frame boundary so a frame never mixes old and new data.
module disp_mux_pwm #(
    parameter int NUM_DIGITS     = 8,
    parameter int PRESCALE       = 1024,
    parameter int BRIGHT_W       = 4,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input logic            clk,
    input logic            reset,
    disp_mux_pwm_if.slave  disp
);
    localparam int PRE_W = $clog2(PRESCALE);
    localparam int DIG_W = $clog2(NUM_DIGITS);
    // Cycles of on-time added per brightness step.
    localparam int SLICE = PRESCALE >> BRIGHT_W;

    localparam logic [7:0]            SEG_BLANK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    logic [PRE_W-1:0]        pre_cnt;
    logic [DIG_W-1:0]        dig_idx;
    logic                    pre_wrap;
    logic                    frame_end;

    logic [8*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_en;
    logic [8*NUM_DIGITS-1:0] act_data;
    logic [NUM_DIGITS-1:0]   act_en;

    logic [31:0]             thresh;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_hot;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [7:0]              sseg_next;

    assign pre_wrap  = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign frame_end = pre_wrap && (dig_idx == DIG_W'(NUM_DIGITS - 1));

    // Slot prescaler and digit scan index; the index steps once per slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
            dig_idx <= '0;
        end else if (pre_wrap) begin
            pre_cnt <= '0;
            dig_idx <= frame_end ? '0 : dig_idx + DIG_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Pending buffer takes every load; active buffer only moves at the frame
    // boundary, taking a coincident load directly so it is not a frame late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_data <= {NUM_DIGITS{SEG_BLANK}};
            pend_en   <= '0;
            act_data  <= {NUM_DIGITS{SEG_BLANK}};
            act_en    <= '0;
        end else begin
            if (disp.load) begin
                pend_data <= disp.seg_data;
                pend_en   <= disp.digit_en;
            end
            if (frame_end) begin
                act_data <= disp.load ? disp.seg_data : pend_data;
                act_en   <= disp.load ? disp.digit_en : pend_en;
            end
        end
    end

    // Lit decision and next pin values; threshold is 32-bit so max brightness
    // (a full slot) cannot wrap.
    always_comb begin
        thresh    = (32'(disp.brightness) + 32'd1) * 32'(SLICE);
        lit       = act_en[dig_idx] && (32'(pre_cnt) < thresh);
        an_hot    = NUM_DIGITS'(1) << dig_idx;
        an_next   = AN_OFF;
        sseg_next = SEG_BLANK;
        if (lit) begin
            an_next   = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
            sseg_next = act_data[8*dig_idx +: 8];
        end
    end

    // Registered pin drivers and frame marker (one cycle behind the scan state).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp.an         <= AN_OFF;
            disp.sseg       <= SEG_BLANK;
            disp.frame_tick <= 1'b0;
        end else begin
            disp.an         <= an_next;
            disp.sseg       <= sseg_next;
            disp.frame_tick <= frame_end;
        end
    end
endmodule

// File: tb/tb_disp_mux_pwm.sv
// Bench for disp_mux_pwm with 4 digits, 16-cycle slots, 2-bit brightness,
// active-low anodes and segments.
module tb_disp_mux_pwm;
    localparam int ND    = 4;
    localparam int PS    = 16;
    localparam int BW    = 2;
    localparam int FRAME = ND * PS;
    localparam int W     = ND + 8 + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    disp_mux_pwm_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) disp();

    disp_mux_pwm #(
        .NUM_DIGITS(ND), .PRESCALE(PS), .BRIGHT_W(BW),
        .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (disp)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Expected display state: scan position of the DUT counters before the
    // next edge, plus the pending/shown buffers as the bench understands them.
    int          pos;
    logic [31:0] act_data, pend_data;
    logic [3:0]  act_en, pend_en;
    bit          in_reset;

    // ---------------- driver tasks ----------------
    // One clock: derive the expected pins after the edge, advance the
    // expected state, then push the expectation once the edge has happened.
    task automatic tick();
        logic [3:0] e_an;
        logic [7:0] e_sseg;
        logic       e_ft;
        int         slot;
        int         off;
        bit         lit;
        if (in_reset) begin
            e_an   = 4'hF;
            e_sseg = 8'hFF;
            e_ft   = 1'b0;
        end else begin
            slot   = pos / PS;
            off    = pos % PS;
            lit    = act_en[slot] && (off < (int'(disp.brightness) + 1) * (PS >> BW));
            e_an   = lit ? ~(4'b0001 << slot) : 4'hF;
            e_sseg = lit ? act_data[slot*8 +: 8] : 8'hFF;
            e_ft   = (pos == FRAME - 1);
            if (pos == FRAME - 1) begin
                act_data = disp.load ? disp.seg_data : pend_data;
                act_en   = disp.load ? disp.digit_en : pend_en;
            end
            if (disp.load) begin
                pend_data = disp.seg_data;
                pend_en   = disp.digit_en;
            end
            pos = (pos + 1) % FRAME;
        end
        @(posedge clk);
        exp_q.push_back({e_an, e_sseg, e_ft});
        #1;
    endtask

    task automatic run_to(input int target);
        while (pos != target) tick();
    endtask

    task automatic drive_load(input logic [31:0] data, input logic [3:0] en);
        disp.seg_data = data;
        disp.digit_en = en;
        disp.load     = 1'b1;
        tick();
        disp.load     = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        exp_q.delete();
        reset    = 1'b1;
        in_reset = 1'b1;
        #1;
        checks++;
        if (disp.an !== 4'hF || disp.sseg !== 8'hFF || disp.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_immediate: an=%b sseg=%h frame_tick=%b, expected an=1111 sseg=ff frame_tick=0",
                     disp.an, disp.sseg, disp.frame_tick);
        end
        pos       = 0;
        act_data  = 32'hFFFF_FFFF;
        pend_data = 32'hFFFF_FFFF;
        act_en    = 4'h0;
        pend_en   = 4'h0;
        repeat (n) tick();
        reset    = 1'b0;
        in_reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({disp.an, disp.sseg, disp.frame_tick} !== e) begin
                    errors++;
                    $display("FAIL scan t=%0t: an=%b sseg=%h frame_tick=%b, expected an=%b sseg=%h frame_tick=%b",
                             $time, disp.an, disp.sseg, disp.frame_tick,
                             e[W-1 -: ND], e[8:1], e[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        disp.seg_data   = '0;
        disp.digit_en   = '0;
        disp.load       = 1'b0;
        disp.brightness = 2'd3;
        in_reset        = 1'b0;
        apply_reset(3);

        // Nothing loaded: all blank, frame_tick every 64 cycles.
        repeat (200) tick();

        // Full-brightness scan of four patterns, digit 0 = B0.
        drive_load(32'hC0F9_A4B0, 4'hF);
        repeat (140) tick();

        // Dimmest (4 of 16) then 12 of 16 cycles per slot.
        run_to(0);
        disp.brightness = 2'd0;
        repeat (FRAME) tick();
        disp.brightness = 2'd2;
        repeat (FRAME) tick();
        disp.brightness = 2'd3;

        // Digits 1 and 3 blanked.
        drive_load(32'hC0F9_A4B0, 4'b0101);
        repeat (130) tick();

        // Mid-frame load: old data until the boundary.
        run_to(20);
        drive_load(32'h80F8_8292, 4'hF);
        repeat (100) tick();

        // Load exactly on the boundary cycle: shown in the frame that follows.
        run_to(FRAME - 1);
        drive_load(32'h99B0_F9C0, 4'hF);
        repeat (FRAME) tick();

        // Brightness change inside a slot.
        run_to(PS + 5);
        disp.brightness = 2'd0;
        repeat (20) tick();
        disp.brightness = 2'd3;

        // Reset during slot 2; enables stay cleared until a new load.
        run_to(2*PS + 5);
        apply_reset(3);
        repeat (80) tick();
        drive_load(32'hC0F9_A4B0, 4'hF);
        repeat (140) tick();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
